// File: rtl/frame_delay_meter.sv
// Purpose: parses delay-test frames from the MAC RX client stream, measures one-way delay and keeps frame statistics.
// Latency: results and counters update on the edge that samples the goodframe/badframe pulse (visible the next cycle).
// Backpressure: none; the MAC stream cannot be stalled, so every byte and status pulse is absorbed as it arrives.
module frame_delay_meter #(
    parameter int          TS_W      = 32,
    parameter logic [15:0] ETHERTYPE = 16'h88B5,
    parameter int          CNT_W     = 32
) (
    input  logic             rx_clk,
    input  logic             reset,
    input  logic [TS_W-1:0]  cur_time,
    input  logic             stats_clear,
    input  logic [7:0]       mac_rx_data,
    input  logic             mac_rx_dvld,
    input  logic             mac_rx_goodframe,
    input  logic             mac_rx_badframe,
    output logic             delay_valid,
    output logic [TS_W-1:0]  delay_value,
    output logic [15:0]      delay_seq,
    output logic [TS_W-1:0]  delay_min,
    output logic [TS_W-1:0]  delay_max,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad,
    output logic [CNT_W-1:0] frames_other,
    output logic [CNT_W-1:0] frames_lost
);

    localparam int        TS_BYTES = TS_W / 8;
    localparam logic [10:0] MIN_LEN = 11'(16 + TS_BYTES);
    localparam logic [10:0] TS_LAST = 11'(16 + TS_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;
    // pend: a new frame's byte 0 arrived together with the previous frame's end pulse
    logic pend, pend_nxt;

    logic [10:0]     byte_cnt;
    logic [TS_W-1:0] sof_time;
    logic [TS_W-1:0] ts_reg;
    logic [15:0]     seq_reg;
    logic [7:0]      et_hi;
    logic            not_test;

    logic [15:0]     exp_seq;
    logic            exp_vld;

    logic in_frame, end_bad, end_good, frame_end, start, byte_take;
    logic commit, other;
    logic [TS_W-1:0] delay_calc;
    logic [15:0]     seq_gap;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Frame boundary decode and next-state logic
    always_comb begin
        state_nxt = state;
        pend_nxt  = 1'b0;
        in_frame  = (state == RECV) || (state == DONE && pend);
        end_bad   = in_frame && mac_rx_badframe;
        end_good  = in_frame && mac_rx_goodframe && !mac_rx_badframe;
        frame_end = end_bad || end_good;
        // a byte with the end pulse is byte 0 of the next frame
        start     = mac_rx_dvld && (!in_frame || frame_end);
        byte_take = mac_rx_dvld && in_frame && !frame_end;
        if (frame_end) begin
            state_nxt = DONE;
            pend_nxt  = start;
        end else if (in_frame || start) begin
            state_nxt = RECV;
        end else begin
            state_nxt = IDLE;
        end
    end

    // Result classification for the frame ending this cycle
    always_comb begin
        commit     = end_good && !not_test && (byte_cnt >= MIN_LEN);
        other      = end_good && !commit;
        delay_calc = sof_time - ts_reg;
        seq_gap    = seq_reg - exp_seq;
    end

    // FSM state register
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Byte capture by offset: EtherType check, sequence number and tx timestamp
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            sof_time <= '0;
            ts_reg   <= '0;
            seq_reg  <= '0;
            et_hi    <= '0;
            not_test <= 1'b0;
        end else if (start) begin
            sof_time <= cur_time;
            byte_cnt <= 11'd1;
            not_test <= 1'b0;
        end else if (byte_take) begin
            if (byte_cnt != 11'h7FF) begin
                byte_cnt <= byte_cnt + 11'd1;
            end
            if (!not_test) begin
                if (byte_cnt == 11'd12) begin
                    et_hi <= mac_rx_data;
                end else if (byte_cnt == 11'd13) begin
                    if ({et_hi, mac_rx_data} != ETHERTYPE) begin
                        not_test <= 1'b1;
                    end
                end else if (byte_cnt == 11'd14) begin
                    seq_reg[15:8] <= mac_rx_data;
                end else if (byte_cnt == 11'd15) begin
                    seq_reg[7:0] <= mac_rx_data;
                end else if (byte_cnt >= 11'd16 && byte_cnt <= TS_LAST) begin
                    ts_reg <= (ts_reg << 8) | TS_W'(mac_rx_data);
                end
            end
        end
    end

    // Result commit, statistics and sequence tracking; clear overrides any update
    always_ff @(posedge rx_clk or negedge reset) begin
        if (!reset) begin
            delay_valid  <= 1'b0;
            delay_value  <= '0;
            delay_seq    <= '0;
            delay_min    <= '1;
            delay_max    <= '0;
            frames_ok    <= '0;
            frames_bad   <= '0;
            frames_other <= '0;
            frames_lost  <= '0;
            exp_seq      <= '0;
            exp_vld      <= 1'b0;
        end else begin
            delay_valid <= 1'b0;
            if (stats_clear) begin
                delay_min    <= '1;
                delay_max    <= '0;
                frames_ok    <= '0;
                frames_bad   <= '0;
                frames_other <= '0;
                frames_lost  <= '0;
                exp_vld      <= 1'b0;
            end else begin
                if (end_bad) begin
                    frames_bad <= sat_add(frames_bad, CNT_W'(1));
                end
                if (other) begin
                    frames_other <= sat_add(frames_other, CNT_W'(1));
                end
                if (commit) begin
                    delay_valid <= 1'b1;
                    delay_value <= delay_calc;
                    delay_seq   <= seq_reg;
                    frames_ok   <= sat_add(frames_ok, CNT_W'(1));
                    if (delay_calc < delay_min) begin
                        delay_min <= delay_calc;
                    end
                    if (delay_calc > delay_max) begin
                        delay_max <= delay_calc;
                    end
                    if (exp_vld && seq_reg != exp_seq) begin
                        frames_lost <= sat_add(frames_lost, CNT_W'(seq_gap));
                    end
                    exp_seq <= seq_reg + 16'd1;
                    exp_vld <= 1'b1;
                end
            end
        end
    end

endmodule
